sent_tx_frame_ctrl: RTL and testbench

Frame sequencer for the SENT transmitter. It drives sent_tx_pulse_gen through one complete SENT frame: sync, status nibble, N data nibbles, CRC nibble and an optional pause pulse. It sequences the pulse generator with the one-hot strobes sync/pulse/pause/idle and advances on its pulse_done. On the host (APB register) side it accepts frames through a one-entry pending buffer with a valid/ready handshake, and computes the SAE J2716 4-bit CRC.

---
 rtl/sent_pkg.sv | 35 +++
 rtl/sent_crc4_step.sv | 19 +
 rtl/sent_tx_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_sent_tx_frame_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sent_pkg.sv
// ---------------------------------------------------------------------------
// sent_pkg
//
// Shared definitions for the SENT transmitter frame sequencer:
//   - sent_state_t     : frame sequencer state encoding
//   - CRC_SEED         : SAE J2716 CRC seed loaded at the start of each frame
//   - SENT_MAX_NIBBLES : largest number of data nibbles a frame may carry
//   - crc4_table()     : multiply-by-x^4 modulo x^4+x^3+x^2+1
// ---------------------------------------------------------------------------
package sent_pkg;

    localparam int         SENT_MAX_NIBBLES = 6;
    localparam logic [3:0] CRC_SEED         = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_PAUSE
    } sent_state_t;

    // Each set bit of c contributes its precomputed residue of x^(4+i) mod P.
    function automatic logic [3:0] crc4_table(input logic [3:0] c);
        logic [3:0] r;
        r = 4'h0;
        if (c[3]) r = r ^ 4'h1;
        if (c[2]) r = r ^ 4'hE;
        if (c[1]) r = r ^ 4'h7;
        if (c[0]) r = r ^ 4'hD;
        return r;
    endfunction

endpackage

// File: rtl/sent_crc4_step.sv
// ---------------------------------------------------------------------------
// sent_crc4_step
//
// One nibble step of the SENT 4-bit CRC (purely combinational).
//   crc_in  : running CRC before this nibble
//   nibble  : data nibble folded in (4'h0 for the final augmentation)
//   crc_out : running CRC after this nibble
// ---------------------------------------------------------------------------
module sent_crc4_step
    import sent_pkg::*;
(
    input  logic [3:0] crc_in,
    input  logic [3:0] nibble,
    output logic [3:0] crc_out
);

    assign crc_out = crc4_table(crc_in) ^ nibble;

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sent_tx_frame_ctrl
//
// Frame sequencer for the SENT transmitter. Walks the pulse generator through
// sync, status nibble, NUM_DATA_NIBBLES data nibbles, CRC nibble and an
// optional pause pulse, advancing on each pulse_done. Frames arrive from the
// host through a one-entry pending buffer.
//
// Ports:
//   ticks        : tick clock shared with the pulse generator
//   reset_n      : asynchronous reset, active low
//   enable       : allow new frames to start
//   pause_en     : append a pause pulse after the CRC nibble
//   frame_valid  : host offers a frame
//   frame_ready  : pending buffer empty (accept on valid && ready)
//   frame_status : status/communication nibble of the offered frame
//   frame_data   : data nibbles, most significant nibble sent first
//   pulse_done   : generator finished the current symbol
//   sync/pulse/pause/idle : one-hot symbol request strobes
//   data_nibble  : nibble value while pulse=1, otherwise 0
//   busy         : frame in progress
//   frame_done   : one-tick strobe after the last symbol of a frame
//   crc_out      : CRC nibble of the most recently transmitted frame
// ---------------------------------------------------------------------------
module sent_tx_frame_ctrl
    import sent_pkg::*;
#(
    parameter int NUM_DATA_NIBBLES = 6
)
(
    input  logic                          ticks,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          pause_en,
    input  logic                          frame_valid,
    output logic                          frame_ready,
    input  logic [3:0]                    frame_status,
    input  logic [4*NUM_DATA_NIBBLES-1:0] frame_data,
    input  logic                          pulse_done,
    output logic                          sync,
    output logic                          pulse,
    output logic                          pause,
    output logic                          idle,
    output logic [3:0]                    data_nibble,
    output logic                          busy,
    output logic                          frame_done,
    output logic [3:0]                    crc_out
);

    localparam int DW = 4 * NUM_DATA_NIBBLES;

    // The index counter is 3 bits wide and never runs past the largest
    // frame the protocol allows.
    localparam int NIB_COUNT =
        (NUM_DATA_NIBBLES > SENT_MAX_NIBBLES) ? SENT_MAX_NIBBLES : NUM_DATA_NIBBLES;
    localparam logic [2:0] LAST_INDEX = 3'(NIB_COUNT - 1);

    sent_state_t state;
    sent_state_t state_next;

    logic [2:0]    index;
    logic [2:0]    index_next;
    logic [2:0]    index_inc;
    logic [3:0]    crc;
    logic [3:0]    crc_next;
    logic [3:0]    crc_out_next;
    logic [3:0]    data_nibble_next;
    logic          frame_done_next;
    logic          load;
    logic          end_frame;

    logic          pend_valid;
    logic [3:0]    pend_status;
    logic [DW-1:0] pend_data;
    logic [3:0]    act_status;
    logic [DW-1:0] act_data;

    logic [3:0]    cur_nibble;
    logic [3:0]    next_nibble;
    logic [3:0]    crc_data;
    logic [3:0]    crc_aug;

    assign index_inc   = index + 3'd1;
    assign cur_nibble  = act_data[DW - 4 - 4*int'(index) +: 4];
    assign next_nibble = act_data[DW - 4 - 4*int'(index_inc) +: 4];

    assign frame_ready = ~pend_valid;
    assign busy        = (state != ST_IDLE);

    sent_crc4_step u_crc_data (
        .crc_in  (crc),
        .nibble  (cur_nibble),
        .crc_out (crc_data)
    );

    // Augmentation pass: running CRC after the last data nibble times x^4.
    sent_crc4_step u_crc_aug (
        .crc_in  (crc_data),
        .nibble  (4'h0),
        .crc_out (crc_aug)
    );

    // Next-state logic. Each symbol is held until pulse_done, and the next
    // symbol is chosen on that same edge so the generator never sees a gap.
    // end_frame funnels the CRC (no pause) and PAUSE exits into one shared
    // back-to-back / idle decision.
    always_comb begin
        state_next       = state;
        index_next       = index;
        crc_next         = crc;
        crc_out_next     = crc_out;
        data_nibble_next = data_nibble;
        frame_done_next  = 1'b0;
        load             = 1'b0;
        end_frame        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (enable && pend_valid) begin
                    state_next       = ST_SYNC;
                    load             = 1'b1;
                    crc_next         = CRC_SEED;
                    data_nibble_next = 4'h0;
                end
            end
            ST_SYNC: begin
                if (pulse_done) begin
                    state_next       = ST_STATUS;
                    data_nibble_next = act_status;
                end
            end
            ST_STATUS: begin
                if (pulse_done) begin
                    state_next       = ST_DATA;
                    index_next       = 3'd0;
                    data_nibble_next = act_data[DW-1 -: 4];
                end
            end
            ST_DATA: begin
                if (pulse_done) begin
                    crc_next = crc_data;
                    if (index == LAST_INDEX) begin
                        state_next       = ST_CRC;
                        data_nibble_next = crc_aug;
                    end else begin
                        index_next       = index_inc;
                        data_nibble_next = next_nibble;
                    end
                end
            end
            ST_CRC: begin
                if (pulse_done) begin
                    crc_out_next = data_nibble;
                    if (pause_en) begin
                        state_next       = ST_PAUSE;
                        data_nibble_next = 4'h0;
                    end else begin
                        end_frame = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (pulse_done) begin
                    end_frame = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (end_frame) begin
            frame_done_next  = 1'b1;
            data_nibble_next = 4'h0;
            if (enable && pend_valid) begin
                state_next = ST_SYNC;
                load       = 1'b1;
                crc_next   = CRC_SEED;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge ticks or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered strobes decoded from the next state so they change on the
    // very edge that moves the FSM, plus the frame datapath.
    always_ff @(posedge ticks or negedge reset_n) begin
        if (!reset_n) begin
            sync        <= 1'b0;
            pulse       <= 1'b0;
            pause       <= 1'b0;
            idle        <= 1'b1;
            data_nibble <= 4'h0;
            frame_done  <= 1'b0;
            crc_out     <= 4'h0;
            crc         <= 4'h0;
            index       <= 3'd0;
        end else begin
            sync        <= (state_next == ST_SYNC);
            pulse       <= (state_next == ST_STATUS) || (state_next == ST_DATA) ||
                           (state_next == ST_CRC);
            pause       <= (state_next == ST_PAUSE);
            idle        <= (state_next == ST_IDLE);
            data_nibble <= data_nibble_next;
            frame_done  <= frame_done_next;
            crc_out     <= crc_out_next;
            crc         <= crc_next;
            index       <= index_next;
        end
    end

    // Pending buffer. It only accepts while empty and only unloads while
    // full, so an accept and a load-out can never fall on the same edge.
    always_ff @(posedge ticks or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid  <= 1'b0;
            pend_status <= 4'h0;
            pend_data   <= '0;
            act_status  <= 4'h0;
            act_data    <= '0;
        end else if (load) begin
            pend_valid <= 1'b0;
            act_status <= pend_status;
            act_data   <= pend_data;
        end else if (frame_valid && !pend_valid) begin
            pend_valid  <= 1'b1;
            pend_status <= frame_status;
            pend_data   <= frame_data;
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sent_tx_frame_ctrl
//
// Scoreboard bench: each accepted frame pushes its expected symbol sequence
// (and CRC) to a queue; a pulse-generator model pops and compares one entry
// every time it completes a symbol.
// ---------------------------------------------------------------------------
module tb_sent_tx_frame_ctrl;

    localparam int N = 6;

    logic           ticks = 1'b0;
    logic           reset_n;
    logic           enable;
    logic           pause_en;
    logic           frame_valid;
    logic           frame_ready;
    logic [3:0]     frame_status;
    logic [4*N-1:0] frame_data;
    logic           pulse_done;
    logic           sync;
    logic           pulse;
    logic           pause;
    logic           idle;
    logic [3:0]     data_nibble;
    logic           busy;
    logic           frame_done;
    logic [3:0]     crc_out;

    typedef struct {
        logic [7:0] sym;
        bit         last;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] crcq[$];

    int total      = 0;
    int bad        = 0;
    int strobe_err = 0;
    int done_seen  = 0;
    int done_exp   = 0;
    bit end_check  = 1'b0;
    bit expect_b2b = 1'b0;
    bit idle_pulses = 1'b0;

    sent_tx_frame_ctrl #(.NUM_DATA_NIBBLES(N)) dut (
        .ticks        (ticks),
        .reset_n      (reset_n),
        .enable       (enable),
        .pause_en     (pause_en),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_status (frame_status),
        .frame_data   (frame_data),
        .pulse_done   (pulse_done),
        .sync         (sync),
        .pulse        (pulse),
        .pause        (pause),
        .idle         (idle),
        .data_nibble  (data_nibble),
        .busy         (busy),
        .frame_done   (frame_done),
        .crc_out      (crc_out)
    );

    always #5 ticks = ~ticks;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Polynomial multiply by x, four times, reducing x^4 to x^3+x^2+1.
    function automatic logic [3:0] mulx4(input logic [3:0] c);
        logic [3:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            r = {r[2:0], 1'b0} ^ (r[3] ? 4'hD : 4'h0);
        end
        return r;
    endfunction

    task automatic pushExpected(input logic [3:0] st, input logic [4*N-1:0] d, input bit with_pause);
        logic [3:0]     c;
        logic [3:0]     nib;
        logic [4*N-1:0] dd;
        exp_t           e;
        c  = 4'h5;
        dd = d;
        e.last = 1'b0;
        e.sym  = 8'h80;
        sbq.push_back(e);
        e.sym = {4'b0100, st};
        sbq.push_back(e);
        for (int i = 0; i < N; i++) begin
            nib = dd[4*N-1 -: 4];
            dd  = dd << 4;
            c   = mulx4(c) ^ nib;
            e.sym = {4'b0100, nib};
            sbq.push_back(e);
        end
        c = mulx4(c);
        e.sym  = {4'b0100, c};
        e.last = !with_pause;
        sbq.push_back(e);
        if (with_pause) begin
            e.sym  = 8'h20;
            e.last = 1'b1;
            sbq.push_back(e);
        end
        crcq.push_back(c);
    endtask

    task automatic applyStimulus(input logic [3:0] st, input logic [4*N-1:0] d);
        int t;
        t = 0;
        @(negedge ticks);
        frame_status = st;
        frame_data   = d;
        frame_valid  = 1'b1;
        while (!frame_ready && t < 2000) begin
            @(negedge ticks);
            t++;
        end
        if (!frame_ready) checkOutput("accept_timeout", 0, 1);
        else pushExpected(st, d, pause_en);
        @(negedge ticks);
        frame_valid = 1'b0;
    endtask

    task automatic waitLeft(input int n, input int budget);
        int t;
        t = 0;
        while ((sbq.size() > n || end_check) && t < budget) begin
            @(negedge ticks);
            t++;
        end
        if (t >= budget) checkOutput("wait_timeout", sbq.size(), n);
    endtask

    // Pulse generator model plus monitor: finishes each symbol after 2..4
    // ticks and scores the symbol that was on the strobes at that moment.
    initial begin : generator
        int         cnt;
        int         sym_len;
        exp_t       e;
        logic [7:0] code;
        logic [3:0] ec;
        cnt        = 0;
        sym_len    = 3;
        pulse_done = 1'b0;
        forever begin
            @(negedge ticks);
            pulse_done = 1'b0;
            if (!reset_n) begin
                cnt = 0;
            end else begin
                if (frame_done) done_seen++;
                if (!$onehot({sync, pulse, pause, idle})) strobe_err++;
                if (!pulse && data_nibble != 4'h0) strobe_err++;
                if (end_check) begin
                    ec = (crcq.size() > 0) ? crcq.pop_front() : 4'h0;
                    checkOutput("frame_done", frame_done, 1);
                    checkOutput("crc_out", crc_out, ec);
                    checkOutput("end_sync", sync, expect_b2b);
                    checkOutput("end_idle", idle, !expect_b2b);
                    if (expect_b2b) checkOutput("reload_ready", frame_ready, 1);
                    expect_b2b = 1'b0;
                    end_check  = 1'b0;
                end
                if (!idle || idle_pulses) begin
                    cnt++;
                    if (cnt >= sym_len) begin
                        pulse_done = 1'b1;
                        cnt        = 0;
                        sym_len    = $urandom_range(2, 4);
                        if (!idle) begin
                            code = {sync, pulse, pause, idle, data_nibble};
                            if (sbq.size() == 0) begin
                                checkOutput("unexpected_symbol", code, 0);
                            end else begin
                                e = sbq.pop_front();
                                checkOutput("symbol", code, e.sym);
                                if (e.last) begin
                                    end_check = 1'b1;
                                    done_exp++;
                                end
                            end
                        end
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    initial begin : main
        reset_n      = 1'b1;
        enable       = 1'b0;
        pause_en     = 1'b1;
        frame_valid  = 1'b0;
        frame_status = 4'h0;
        frame_data   = '0;
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_sync", sync, 0);
        checkOutput("rst_pulse", pulse, 0);
        checkOutput("rst_pause", pause, 0);
        checkOutput("rst_nibble", data_nibble, 0);
        checkOutput("rst_ready", frame_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", frame_done, 0);
        checkOutput("rst_crc", crc_out, 0);
        repeat (3) @(negedge ticks);
        reset_n = 1'b1;
        @(negedge ticks);

        $display("[TB] all-zero frame with pause");
        enable   = 1'b1;
        pause_en = 1'b1;
        applyStimulus(4'h0, 24'h000000);
        checkOutput("lat_idle", idle, 1);
        @(negedge ticks);
        checkOutput("lat_sync", sync, 1);
        checkOutput("lat_busy", busy, 1);
        waitLeft(0, 2000);
        checkOutput("t1_crc", crc_out, 4'h5);

        $display("[TB] status A data F00000 no pause");
        pause_en = 1'b0;
        applyStimulus(4'hA, 24'hF00000);
        waitLeft(0, 2000);
        checkOutput("t2_crc", crc_out, 4'h9);

        $display("[TB] back-to-back frames");
        applyStimulus(4'h1, 24'h123456);
        waitLeft(6, 2000);
        expect_b2b = 1'b1;
        applyStimulus(4'h2, 24'h654321);
        checkOutput("t3_ready_low", frame_ready, 0);
        waitLeft(0, 4000);
        checkOutput("t3_idle", idle, 1);

        $display("[TB] enable dropped mid-frame");
        pause_en = 1'b1;
        applyStimulus(4'h3, 24'hABCDEF);
        waitLeft(7, 2000);
        enable = 1'b0;
        applyStimulus(4'h4, 24'h111111);
        waitLeft(10, 2000);
        repeat (20) @(negedge ticks);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_idle", idle, 1);
        checkOutput("t4_ready", frame_ready, 0);
        checkOutput("t4_no_start", sbq.size(), 10);
        enable = 1'b1;
        waitLeft(0, 2000);

        $display("[TB] reset during data");
        pause_en = 1'b0;
        applyStimulus(4'h5, 24'h2468AC);
        waitLeft(6, 2000);
        applyStimulus(4'h6, 24'h13579B);
        @(negedge ticks);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_idle", idle, 1);
        checkOutput("t5_sync", sync, 0);
        checkOutput("t5_pulse", pulse, 0);
        checkOutput("t5_pause", pause, 0);
        checkOutput("t5_nibble", data_nibble, 0);
        checkOutput("t5_ready", frame_ready, 1);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", frame_done, 0);
        checkOutput("t5_crc", crc_out, 0);
        sbq.delete();
        crcq.delete();
        end_check  = 1'b0;
        expect_b2b = 1'b0;
        repeat (3) @(negedge ticks);
        reset_n = 1'b1;
        @(negedge ticks);
        checkOutput("t5_post_idle", idle, 1);
        repeat (10) @(negedge ticks);
        checkOutput("t5_post_busy", busy, 0);
        checkOutput("t5_post_ready", frame_ready, 1);

        $display("[TB] idle pulse_done and held frame_valid");
        enable      = 1'b0;
        pause_en    = 1'b1;
        idle_pulses = 1'b1;
        repeat (12) @(negedge ticks);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_idle", idle, 1);
        frame_status = 4'h7;
        frame_data   = 24'h0F0F0F;
        frame_valid  = 1'b1;
        pushExpected(4'h7, 24'h0F0F0F, 1'b1);
        repeat (8) @(negedge ticks);
        frame_valid = 1'b0;
        checkOutput("t6_ready_low", frame_ready, 0);
        checkOutput("t6_still_idle", busy, 0);
        idle_pulses = 1'b0;
        enable      = 1'b1;
        waitLeft(0, 2000);
        repeat (10) @(negedge ticks);
        checkOutput("t6_one_accept", frame_ready, 1);
        checkOutput("t6_end_busy", busy, 0);

        checkOutput("strobe_err", strobe_err, 0);
        checkOutput("done_count", done_seen, done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
